alu_input_loader: RTL and testbench

Front-end stage that captures ALU operands and opcode from a shared switch bus using three push-buttons, and drives the `alu` inputs `num1`, `num2` and `opcode` directly. Each button is synchronised, debounced and edge-detected. On a debounced press, the current switch value is latched into the corresponding holding register. Per-register loaded flags, a combined valid flag and an update strobe let downstream logic know when the ALU inputs are complete and when they change.

---
 rtl/alu_input_loader.sv | 103 ++++++++++
 tb/tb_alu_input_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_loader.sv
// ============================================================================
// Module   : alu_input_loader
// Captures ALU operands and opcode from a shared switch bus on debounced
// push-button presses, with loaded/valid flags and an update strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_input_loader #(
    parameter int DATA_WIDTH      = 8,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   switches,
    input  logic                    btn_num1,
    input  logic                    btn_num2,
    input  logic                    btn_opcode,
    output logic [DATA_WIDTH-1:0]   num1,
    output logic [DATA_WIDTH-1:0]   num2,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [2:0]              loaded,
    output logic                    operands_valid,
    output logic                    update
);

    localparam int              CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]              w_btn;
    logic [2:0]              w_press;
    logic [DATA_WIDTH-1:0]   r_num1;
    logic [DATA_WIDTH-1:0]   r_num2;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [2:0]              r_loaded;
    logic                    r_update;

    assign w_btn = {btn_opcode, btn_num2, btn_num1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync0;
            logic             r_sync1;
            logic             r_deb;
            logic             r_deb_q;
            logic [CNT_W-1:0] r_cnt;

            // A level change is accepted only after DEBOUNCE_CYCLES
            // consecutive cycles of disagreement with the debounced level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync0 <= 1'b0;
                    r_sync1 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_q <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync0 <= w_btn[gi];
                    r_sync1 <= r_sync0;
                    r_deb_q <= r_deb;
                    if (r_sync1 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_deb <= r_sync1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_deb & ~r_deb_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num1   <= '0;
            r_num2   <= '0;
            r_opcode <= '0;
            r_loaded <= '0;
            r_update <= 1'b0;
        end else begin
            if (w_press[0]) r_num1   <= switches;
            if (w_press[1]) r_num2   <= switches;
            if (w_press[2]) r_opcode <= switches[OPCODE_WIDTH-1:0];
            r_loaded <= r_loaded | w_press;
            // Strobe when a load leaves all three registers populated.
            r_update <= (|w_press) & (&(r_loaded | w_press));
        end
    end

    assign num1           = r_num1;
    assign num2           = r_num2;
    assign opcode         = r_opcode;
    assign loaded         = r_loaded;
    assign operands_valid = &r_loaded;
    assign update         = r_update;

endmodule

`default_nettype wire

// File: tb/tb_alu_input_loader.sv
// ============================================================================
// Module   : tb_alu_input_loader
// Scoreboard bench for alu_input_loader with DEBOUNCE_CYCLES = 4.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_input_loader;

    localparam int DW  = 8;
    localparam int OW  = 6;
    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] switches = '0;
    logic          btn_num1 = 1'b0;
    logic          btn_num2 = 1'b0;
    logic          btn_opcode = 1'b0;
    logic [DW-1:0] num1;
    logic [DW-1:0] num2;
    logic [OW-1:0] opcode;
    logic [2:0]    loaded;
    logic          operands_valid;
    logic          update;

    alu_input_loader #(
        .DATA_WIDTH      (DW),
        .OPCODE_WIDTH    (OW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .switches       (switches),
        .btn_num1       (btn_num1),
        .btn_num2       (btn_num2),
        .btn_opcode     (btn_opcode),
        .num1           (num1),
        .num2           (num2),
        .opcode         (opcode),
        .loaded         (loaded),
        .operands_valid (operands_valid),
        .update         (update)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] n1;
        logic [DW-1:0] n2;
        logic [OW-1:0] op;
        logic [2:0]    ld;
        logic          v;
        logic          up;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_n1 = '0;
    logic [DW-1:0] m_n2 = '0;
    logic [OW-1:0] m_op = '0;
    logic [2:0]    m_ld = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_n1 = '0; m_n2 = '0; m_op = '0; m_ld = '0;
    endtask

    task automatic expect_load(input logic [2:0] mask, input logic [DW-1:0] sw, input int at);
        exp_t e;
        e.up = &(m_ld | mask);
        if (mask[0]) m_n1 = sw;
        if (mask[1]) m_n2 = sw;
        if (mask[2]) m_op = sw[OW-1:0];
        m_ld = m_ld | mask;
        e.cyc = at; e.n1 = m_n1; e.n2 = m_n2; e.op = m_op; e.ld = m_ld; e.v = &m_ld;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] mask, input logic [DW-1:0] sw, input int hold);
        switches = sw;
        {btn_opcode, btn_num2, btn_num1} = mask;
        expect_load(mask, sw, cyc + LAT);
        tick(hold);
        {btn_opcode, btn_num2, btn_num1} = 3'b000;
        tick(14);
    endtask

    // Monitor: any visible output change or update strobe is one event.
    logic [24:0] mon_prev = '0;
    logic [24:0] mon_cur;
    exp_t        mon_e;
    always @(negedge clk) begin
        mon_cur = {num1, num2, opcode, loaded};
        if (!rst_n) begin
            mon_prev = mon_cur;
        end else if (mon_cur !== mon_prev || update !== 1'b0) begin
            mon_prev = mon_cur;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got %h upd %b at cycle %0d, expected no event",
                         mon_cur, update, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("event_values", {37'd0, mon_cur, operands_valid, update},
                    {37'd0, mon_e.n1, mon_e.n2, mon_e.op, mon_e.ld, mon_e.v, mon_e.up});
                chk("event_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inputs toggling
        rst_n = 1'b0;
        tick(1);
        btn_num1 = 1'b1; switches = 8'hFF;
        tick(2);
        btn_num2 = 1'b1; btn_opcode = 1'b1;
        tick(2);
        chk("reset_hold", {num1, num2, opcode, loaded, operands_valid, update}, 0);
        {btn_opcode, btn_num2, btn_num1} = 3'b000; switches = '0;
        tick(3);
        chk("reset_idle", {num1, num2, opcode, loaded, operands_valid, update}, 0);
        rst_n = 1'b1;
        tick(10);
        chk("after_release", {num1, num2, opcode, loaded, operands_valid, update}, 0);

        // Basic load sequence, then a reload while valid
        press(3'b001, 8'h01, 10);
        press(3'b010, 8'h02, 10);
        press(3'b100, 8'hE4, 10);
        press(3'b001, 8'h5A, 10);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {num1, num2, opcode, loaded, operands_valid, update}, 0);
        tick(2);
        model_reset();
        rst_n = 1'b1;
        tick(3);

        // Bounce rejection, then clean loads
        btn_num1 = 1'b1; tick(3);
        btn_num1 = 1'b0; tick(1);
        btn_num1 = 1'b1; tick(3);
        btn_num1 = 1'b0; tick(20);
        chk("bounce_loaded", loaded, 3'b000);
        press(3'b001, 8'h33, 10);
        press(3'b100, 8'hC7, 10);

        // Held button: switches change after the load must not be captured
        switches = 8'h11; btn_num2 = 1'b1;
        expect_load(3'b010, 8'h11, cyc + LAT);
        tick(10);
        switches = 8'h22;
        tick(40);
        btn_num2 = 1'b0;
        tick(14);
        press(3'b010, 8'h22, 10);

        // Simultaneous presses
        rst_n = 1'b0;
        tick(2);
        model_reset();
        rst_n = 1'b1;
        tick(3);
        press(3'b111, 8'hA5, 10);

        // Reset during debounce, button still held at release
        switches = 8'h99; btn_opcode = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        tick(3);
        chk("mid_debounce_reset", {num1, num2, opcode, loaded, operands_valid, update}, 0);
        model_reset();
        switches = 8'h3C;
        rst_n = 1'b1;
        expect_load(3'b100, 8'h3C, cyc + LAT);
        tick(10);
        btn_opcode = 1'b0;
        tick(14);

        tick(20);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
